n_term_pipe: RTL and testbench

Parametrised north-edge termination tile. It loops NUM_CH northbound single-hop wires back onto the southbound single-hop wires, with each channel's routing mode set by one configuration frame. Per channel, that mode is combinational pass-through, a PIPE_DEPTH-stage registered loopback, tie-low or tie-high. The block sits in the top fabric row in place of the fixed single-channel pass-through terminator, and forwards clock, reset, frame strobes and frame data to the tile below.

---
 rtl/n_term_pipe.sv | 109 ++++++++++
 tb/tb_n_term_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/n_term_pipe.sv
// North-edge termination tile: loops from_N back onto to_S with a per-channel mode
// (pass / registered / low / high) set by one config frame. Optional monitor: N_TERM_PIPE_ACTMON_EN.
module n_term_pipe #(
    parameter int unsigned NUM_CH          = 8,
    parameter int unsigned PIPE_DEPTH      = 1,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned CFG_FRAME       = 0
) (
    input  logic                       UserCLK,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          from_N,
    output logic [NUM_CH-1:0]          to_S,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    output logic                       rsto
`ifdef N_TERM_PIPE_ACTMON_EN
    ,
    output logic [NUM_CH-1:0]          act
`endif
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_REG  = 2'b01,
        MODE_LOW  = 2'b10,
        MODE_HIGH = 2'b11
    } mode_e;

    mode_e             mode_q  [NUM_CH];
    logic [NUM_CH-1:0] stage_q [PIPE_DEPTH];
    logic [NUM_CH-1:0] reg_out;
    logic              cfg_wr;
    logic              unused_frame_data;

    assign cfg_wr            = FrameStrobe[CFG_FRAME];
    assign unused_frame_data = ^FrameData;

    // Reset value LOW forces to_S low asynchronously through the output mux.
    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_LOW;
            end
        end else if (cfg_wr) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_e'(FrameData[2*i +: 2]);
            end
        end
    end

    // Pipeline runs regardless of mode so a switch into REG shows history at once.
    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= from_N;
            for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign reg_out = stage_q[PIPE_DEPTH-1];

    always_comb begin
        to_S = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            case (mode_q[i])
                MODE_PASS: to_S[i] = from_N[i];
                MODE_REG:  to_S[i] = reg_out[i];
                MODE_LOW:  to_S[i] = 1'b0;
                MODE_HIGH: to_S[i] = 1'b1;
                default:   to_S[i] = 1'b0;
            endcase
        end
    end

    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;
    assign rsto          = rst;

`ifdef N_TERM_PIPE_ACTMON_EN
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] act_q;

    // A mode write clears the sticky flags and wins over a same-edge set.
    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            act_q  <= '0;
        end else begin
            prev_q <= from_N;
            if (cfg_wr) begin
                act_q <= '0;
            end else begin
                act_q <= act_q | (from_N & ~prev_q);
            end
        end
    end

    assign act = act_q;
`endif

endmodule

// File: tb/tb_n_term_pipe.sv
// Directed bench for n_term_pipe (NUM_CH=8, PIPE_DEPTH=3): vector table plus
// hand sequences for async reset, forwarding and the optional activity monitor.
module tb_n_term_pipe;

    localparam int unsigned NCH = 8;
    localparam int unsigned PD  = 3;
    localparam int unsigned NV  = 25;

    logic            clk;
    logic            rst;
    logic [NCH-1:0]  from_N;
    logic [NCH-1:0]  to_S;
    logic [31:0]     FrameData;
    logic [19:0]     FrameStrobe;
    logic [19:0]     FrameStrobe_O;
    logic            UserCLKo;
    logic            rsto;
`ifdef N_TERM_PIPE_ACTMON_EN
    logic [NCH-1:0]  act;
`endif

    int n_cmp;
    int n_bad;

    n_term_pipe #(
        .NUM_CH          (NCH),
        .PIPE_DEPTH      (PD),
        .MaxFramesPerCol (20),
        .FrameBitsPerRow (32),
        .CFG_FRAME       (0)
    ) dut (
        .UserCLK       (clk),
        .rst           (rst),
        .from_N        (from_N),
        .to_S          (to_S),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (FrameStrobe_O),
        .UserCLKo      (UserCLKo),
        .rsto          (rsto)
`ifdef N_TERM_PIPE_ACTMON_EN
        ,
        .act           (act)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [19:0] stb;
        logic [31:0] fd;
        logic [7:0]  fn;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        from_N = '0;
        FrameData = '0;
        FrameStrobe = '0;

        // {rst, strobe, FrameData, from_N, expected to_S after the edge}
        vecs[0]  = '{1'b0, 20'h0, 32'h0000_0000, 8'hFF, 8'h00}; // in reset
        vecs[1]  = '{1'b0, 20'h1, 32'h0000_0000, 8'hFF, 8'h00}; // strobe in reset ignored
        vecs[2]  = '{1'b1, 20'h0, 32'h0000_0000, 8'hFF, 8'h00}; // released, still LOW
        vecs[3]  = '{1'b1, 20'h0, 32'h0000_0000, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 20'h1, 32'h0000_0000, 8'hA5, 8'hA5}; // all PASS
        vecs[5]  = '{1'b1, 20'h0, 32'h0000_0000, 8'h3C, 8'h3C};
        vecs[6]  = '{1'b1, 20'h0, 32'h0000_0000, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 20'h0, 32'h0000_0000, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 20'h0, 32'h0000_0000, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 20'h1, 32'h0000_5555, 8'h3C, 8'h00}; // all REG, edge 1
        vecs[10] = '{1'b1, 20'h0, 32'h0000_5555, 8'h3C, 8'h00}; // edge 2
        vecs[11] = '{1'b1, 20'h0, 32'h0000_5555, 8'h3C, 8'h3C}; // edge 3
        vecs[12] = '{1'b1, 20'h0, 32'h0000_5555, 8'h00, 8'h3C};
        vecs[13] = '{1'b1, 20'h0, 32'h0000_5555, 8'h00, 8'h3C};
        vecs[14] = '{1'b1, 20'h0, 32'h0000_5555, 8'h00, 8'h00};
        vecs[15] = '{1'b1, 20'h1, 32'h0000_00E4, 8'h0F, 8'h09}; // PASS,REG,LOW,HIGH
        vecs[16] = '{1'b1, 20'h0, 32'h0000_00E4, 8'h0F, 8'h09};
        vecs[17] = '{1'b1, 20'h0, 32'h0000_00E4, 8'h0F, 8'h0B}; // REG bit lands
        vecs[18] = '{1'b1, 20'h1, 32'h0000_FFFF, 8'h0F, 8'hFF}; // held strobe: HIGH
        vecs[19] = '{1'b1, 20'h1, 32'h0000_AAAA, 8'h0F, 8'h00}; // then LOW wins
        vecs[20] = '{1'b1, 20'h0, 32'h0000_0000, 8'h0F, 8'h00}; // no strobe, no load
        vecs[21] = '{1'b1, 20'h1, 32'hFFFF_0000, 8'h5A, 8'h5A}; // upper bits ignored
        vecs[22] = '{1'b1, 20'h2, 32'h0000_AAAA, 8'h5A, 8'h5A}; // other strobe ignored
        vecs[23] = '{1'b0, 20'h1, 32'h0000_0000, 8'hFF, 8'h00}; // rst beats strobe
        vecs[24] = '{1'b1, 20'h1, 32'h0000_0000, 8'hFF, 8'hFF}; // first edge after release writes

        for (int i = 0; i < NV; i++) begin
            rst         = vecs[i].rst;
            FrameStrobe = vecs[i].stb;
            FrameData   = vecs[i].fd;
            from_N      = vecs[i].fn;
            step();
            check($sformatf("vec%0d_to_S", i), 32'(to_S), 32'(vecs[i].exp));
        end

        // PASS is combinational within the cycle; forwarded signals copy inputs
        FrameStrobe = 20'hABCDE;
        from_N = 8'hA5;
        #1;
        check("pass_comb", 32'(to_S), 32'h0000_00A5);
        check("strobe_fwd", 32'(FrameStrobe_O), 32'h000A_BCDE);
        check("clk_fwd_hi", 32'(UserCLKo), 32'h1);
        check("rst_fwd_hi", 32'(rsto), 32'h1);
        FrameStrobe = '0;
        @(negedge clk);
        #1;
        check("clk_fwd_lo", 32'(UserCLKo), 32'h0);

        // Fill REG pipeline with ones, then pulse reset asynchronously
        FrameStrobe = 20'h1;
        FrameData = 32'h0000_5555;
        from_N = 8'hFF;
        step();
        FrameStrobe = '0;
        step();
        step();
        check("reg_full", 32'(to_S), 32'h0000_00FF);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_to_S", 32'(to_S), 32'h0);
        check("rst_fwd_lo", 32'(rsto), 32'h0);
`ifdef N_TERM_PIPE_ACTMON_EN
        check("act_rst", 32'(act), 32'h0);
`endif
        step();
        rst = 1'b1;
        #1;
        check("post_rst_low", 32'(to_S), 32'h0);
        FrameStrobe = 20'h1;
        step();
        check("rereg_e1", 32'(to_S), 32'h0);
        FrameStrobe = '0;
        step();
        check("rereg_e2", 32'(to_S), 32'h0);
        step();
        check("rereg_e3", 32'(to_S), 32'h0000_00FF);

`ifdef N_TERM_PIPE_ACTMON_EN
        from_N = 8'h00;
        FrameStrobe = 20'h1;
        step();
        check("act_clr_wr", 32'(act), 32'h0);
        FrameStrobe = '0;
        step();
        check("act_quiet", 32'(act), 32'h0);
        from_N = 8'h04;
        step();
        check("act_set", 32'(act), 32'h0000_0004);
        from_N = 8'h00;
        step();
        check("act_sticky", 32'(act), 32'h0000_0004);
        from_N = 8'h10;
        FrameStrobe = 20'h1;
        step();
        check("act_clr_prio", 32'(act), 32'h0);
        FrameStrobe = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
